// File: rtl/maxnet_engine.sv
// Time-multiplexed Maxnet: loads N scores, then repeatedly subtracts eps*(S - x_k)
// from each score with one shared adder/multiplier until at most one survives.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_LOAD   | accept scores x_0..x_{N-1}; once ptr reaches N, go to S_CHECK
// S_CHECK  | decide: finished, hit iteration cap, or start another iteration
// S_SUM    | accumulate S over all x, one channel per cycle
// S_UPDATE | x_k <= ReLU(x_k - eps*(S - x_k)) one channel per cycle, recount nz
// S_DONE   | hold result until out_valid_o & out_ready_i
module maxnet_engine #(
  parameter int N        = 4,
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 8,
  parameter int EPS      = 51,
  parameter int MAX_ITER = 16,
  parameter int IDX_W    = $clog2(N),
  parameter int IT_W     = $clog2(MAX_ITER + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              busy_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [IDX_W-1:0]  win_idx_o,
  output logic [DATA_W-1:0] win_value_o,
  output logic [IT_W-1:0]   iter_count_o,
  output logic              timeout_o,
  output logic              all_zero_o
);

  localparam int ACC_W  = DATA_W + $clog2(N);
  localparam int PROD_W = ACC_W + FRAC_W;
  localparam int PTR_W  = $clog2(N + 1);

  typedef enum logic [2:0] {S_LOAD, S_CHECK, S_SUM, S_UPDATE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] x_q [N];
  logic [DATA_W-1:0] x_d [N];
  logic [DATA_W-1:0] orig_q [N];
  logic [DATA_W-1:0] orig_d [N];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  nz_q, nz_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [IDX_W-1:0]  win_idx_q, win_idx_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [IT_W-1:0]   iter_q, iter_d;
  logic              timeout_q, timeout_d;
  logic              all_zero_q, all_zero_d;

  // Lowest index holding the largest x; also the sole non-zero index when nz<=1
  logic [IDX_W-1:0]  best_idx;
  logic [DATA_W-1:0] best_val;
  always_comb begin
    best_idx = '0;
    best_val = x_q[0];
    for (int i = 1; i < N; i++) begin
      if (x_q[i] > best_val) begin
        best_val = x_q[i];
        best_idx = IDX_W'(i);
      end
    end
  end

  // Shared datapath: S is frozen during UPDATE, so in-place writes are safe
  logic [DATA_W-1:0] xk;
  logic [ACC_W-1:0]  diff;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  p;
  logic [DATA_W-1:0] x_new;

  assign xk    = x_q[k_q];
  assign diff  = sum_q - ACC_W'(xk);
  assign prod  = PROD_W'(EPS) * PROD_W'(diff);
  assign p     = ACC_W'(prod >> FRAC_W);
  assign x_new = (p >= ACC_W'(xk)) ? '0 : xk - p[DATA_W-1:0];

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    orig_d      = orig_q;
    ptr_d       = ptr_q;
    nz_d        = nz_q;
    k_d         = k_q;
    win_idx_d   = win_idx_q;
    sum_d       = sum_q;
    iter_d      = iter_q;
    timeout_d   = timeout_q;
    all_zero_d  = all_zero_q;
    in_ready_o  = 1'b0;
    busy_o      = 1'b1;
    out_valid_o = 1'b0;

    case (state_q)
      S_LOAD: begin
        busy_o = 1'b0;
        if (ptr_q == PTR_W'(N)) begin
          state_d = S_CHECK;
        end else begin
          in_ready_o = 1'b1;
          if (in_valid_i) begin
            x_d[ptr_q[IDX_W-1:0]]    = in_data_i;
            orig_d[ptr_q[IDX_W-1:0]] = in_data_i;
            ptr_d = ptr_q + PTR_W'(1);
            nz_d  = nz_q + PTR_W'(in_data_i != '0);
          end
        end
      end

      S_CHECK: begin
        if (nz_q <= PTR_W'(1)) begin
          state_d    = S_DONE;
          win_idx_d  = best_idx;
          all_zero_d = (nz_q == '0);
        end else if (iter_q == IT_W'(MAX_ITER)) begin
          state_d   = S_DONE;
          win_idx_d = best_idx;
          timeout_d = 1'b1;
        end else begin
          state_d = S_SUM;
          sum_d   = '0;
          k_d     = '0;
        end
      end

      S_SUM: begin
        sum_d = sum_q + ACC_W'(xk);
        if (k_q == IDX_W'(N - 1)) begin
          k_d     = '0;
          state_d = S_UPDATE;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end

      S_UPDATE: begin
        x_d[k_q] = x_new;
        nz_d     = ((k_q == '0) ? '0 : nz_q) + PTR_W'(x_new != '0);
        if (k_q == IDX_W'(N - 1)) begin
          k_d     = '0;
          iter_d  = iter_q + IT_W'(1);
          state_d = S_CHECK;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d    = S_LOAD;
          ptr_d      = '0;
          nz_d       = '0;
          iter_d     = '0;
          timeout_d  = 1'b0;
          all_zero_d = 1'b0;
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_LOAD;
      for (int i = 0; i < N; i++) begin
        x_q[i]    <= '0;
        orig_q[i] <= '0;
      end
      ptr_q      <= '0;
      nz_q       <= '0;
      k_q        <= '0;
      win_idx_q  <= '0;
      sum_q      <= '0;
      iter_q     <= '0;
      timeout_q  <= 1'b0;
      all_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      orig_q     <= orig_d;
      ptr_q      <= ptr_d;
      nz_q       <= nz_d;
      k_q        <= k_d;
      win_idx_q  <= win_idx_d;
      sum_q      <= sum_d;
      iter_q     <= iter_d;
      timeout_q  <= timeout_d;
      all_zero_q <= all_zero_d;
    end
  end

  assign win_idx_o    = win_idx_q;
  assign win_value_o  = orig_q[win_idx_q];
  assign iter_count_o = iter_q;
  assign timeout_o    = timeout_q;
  assign all_zero_o   = all_zero_q;

endmodule
